// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths and state/owner types for the unified memory port arbiter.
package cpu_mem_pkg;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-port signals of the arbiter.
// master = requesters/memory side, slave = arbiter side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM loads/stores onto one memory port,
// with a bounded data-priority counter so fetch cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W     = cpu_mem_pkg::DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_port_arbiter_if.slave     io_bus
);
    import cpu_mem_pkg::*;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);

    arb_state_t        r_state, w_next;
    owner_t            r_owner, w_owner;
    logic [2:0]        r_starve, r_lat;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_rdata, r_dm_rdata;
    logic              r_we;
    logic              w_any, w_contest, w_last, w_start;

    always_comb begin
        w_any     = io_bus.if_req || io_bus.dm_req;
        w_contest = io_bus.if_req && io_bus.dm_req;
        w_last    = r_lat == 3'd1;
        w_owner   = (io_bus.if_req && (!io_bus.dm_req || r_starve == STARVE_LIM)) ? OWN_IF : OWN_DM;
        w_start   = r_state == IDLE && w_any;
        w_next    = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ACCESS : IDLE;
            ACCESS:  w_next = WAIT;
            WAIT:    w_next = w_last ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= OWN_IF;
            r_starve   <= '0;
            r_lat      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_next;
            // Owner and its request fields are latched at arbitration so the memory port is fully registered.
            if (w_start) begin
                r_owner  <= w_owner;
                r_addr   <= w_owner == OWN_IF ? io_bus.if_addr : io_bus.dm_addr;
                r_wdata  <= w_owner == OWN_DM ? io_bus.dm_wdata : '0;
                r_we     <= w_owner == OWN_DM && io_bus.dm_we;
                r_starve <= w_owner == OWN_IF ? 3'd0 :
                            (w_contest && r_starve < STARVE_LIM) ? r_starve + 3'd1 : r_starve;
            end
            if (r_state == ACCESS)
                r_lat <= LAT_LOAD;
            else if (r_state == WAIT)
                r_lat <= r_lat - 3'd1;
            if (r_state == WAIT && w_last && !r_we) begin
                if (r_owner == OWN_IF)
                    r_if_rdata <= io_bus.mem_rdata;
                else
                    r_dm_rdata <= io_bus.mem_rdata;
            end
        end
    end

    assign io_bus.mem_en    = r_state == ACCESS;
    assign io_bus.mem_we    = r_state == ACCESS && r_we;
    assign io_bus.mem_addr  = r_addr;
    assign io_bus.mem_wdata = r_wdata;
    assign io_bus.if_gnt    = r_state == ACCESS && r_owner == OWN_IF;
    assign io_bus.dm_gnt    = r_state == ACCESS && r_owner == OWN_DM;
    assign io_bus.if_rvalid = r_state == RESP && r_owner == OWN_IF;
    assign io_bus.dm_rvalid = r_state == RESP && r_owner == OWN_DM;
    assign io_bus.if_rdata  = r_if_rdata;
    assign io_bus.dm_rdata  = r_dm_rdata;
    assign io_bus.busy      = r_state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for the memory port arbiter; u0 runs MEM_LAT=1,
// u1 runs MEM_LAT=4 with an address-derived memory pattern.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        is_if;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        tv [8];
    logic [10:0] seq;
    int          cyc, last, ng, nrv;
    logic [31:0] m0 [1024];
    logic [31:0] p0;
    logic [31:0] p1 [4];

    always #5 clk = ~clk;

    mem_port_arbiter_if b0 ();
    mem_port_arbiter_if b1 ();

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u0 (.clk(clk), .rst_n(rst_n), .io_bus(b0.slave));
    mem_port_arbiter #(.MEM_LAT(4), .STARVE_MAX(3)) u1 (.clk(clk), .rst_n(rst_n), .io_bus(b1.slave));

    // u0 memory: one-cycle registered read; u1 memory: four-stage pipe of a pattern.
    always @(posedge clk) begin
        if (!rst_n)
            m0[4] <= 32'hDEADBEEF;
        else if (b0.mem_en) begin
            p0 <= m0[b0.mem_addr];
            if (b0.mem_we)
                m0[b0.mem_addr] <= b0.mem_wdata;
        end
        p1[0] <= b1.mem_en ? (32'hA5000000 | 32'(b1.mem_addr)) : 32'h0;
        for (int i = 1; i < 4; i++)
            p1[i] <= p1[i-1];
    end
    assign b0.mem_rdata = p0;
    assign b1.mem_rdata = p1[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_busy"}, b0.busy, 0);
        chk({tag, "_if_gnt"}, b0.if_gnt, 0);
        chk({tag, "_dm_gnt"}, b0.dm_gnt, 0);
        chk({tag, "_if_rvalid"}, b0.if_rvalid, 0);
        chk({tag, "_dm_rvalid"}, b0.dm_rvalid, 0);
        chk({tag, "_mem_en"}, b0.mem_en, 0);
        chk({tag, "_mem_we"}, b0.mem_we, 0);
        chk({tag, "_mem_addr"}, 32'(b0.mem_addr), 0);
        chk({tag, "_if_rdata"}, b0.if_rdata, 0);
        chk({tag, "_dm_rdata"}, b0.dm_rdata, 0);
    endtask

    task automatic wait_gnt();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(b0.if_gnt || b0.dm_gnt) && n < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv = '{
            '{1'b1, 1'b0, 10'h004, 32'h0,        32'hDEADBEEF},
            '{1'b0, 1'b1, 10'h3FD, 32'h00000001, 32'h00000000},
            '{1'b0, 1'b0, 10'h3FD, 32'h0,        32'h00000001},
            '{1'b1, 1'b0, 10'h3FD, 32'h0,        32'h00000001},
            '{1'b0, 1'b1, 10'h010, 32'h12345678, 32'h00000001},
            '{1'b0, 1'b0, 10'h010, 32'h0,        32'h12345678},
            '{1'b1, 1'b0, 10'h010, 32'h0,        32'h12345678},
            '{1'b0, 1'b0, 10'h004, 32'h0,        32'hDEADBEEF}
        };
        b0.dm_we = 0; b0.dm_wdata = 0; b1.if_req = 0; b1.dm_req = 0;
        b1.if_addr = 0; b1.dm_addr = 0; b1.dm_we = 0; b1.dm_wdata = 0;
        b0.if_req = 1; b0.dm_req = 1; b0.if_addr = 10'h004; b0.dm_addr = 10'h3FD;
        repeat (3) @(posedge clk);
        #1;
        rst_chk("rst");
        rst_n = 1;
        tick();
        chk("rel_dm_gnt", b0.dm_gnt, 1);
        chk("rel_if_gnt", b0.if_gnt, 0);
        b0.if_req = 0; b0.dm_req = 0;
        repeat (4) tick();
        chk("rel_idle", b0.busy, 0);
        #2 rst_n = 0;
        #2 rst_n = 1;

        foreach (tv[k]) begin
            tick();
            b0.if_req = tv[k].is_if; b0.dm_req = !tv[k].is_if;
            b0.if_addr = tv[k].addr; b0.dm_addr = tv[k].addr;
            b0.dm_we = tv[k].we; b0.dm_wdata = tv[k].wdata;
            tick();
            chk($sformatf("v%0d_if_gnt", k), b0.if_gnt, tv[k].is_if);
            chk($sformatf("v%0d_dm_gnt", k), b0.dm_gnt, !tv[k].is_if);
            chk($sformatf("v%0d_mem_en", k), b0.mem_en, 1);
            chk($sformatf("v%0d_mem_we", k), b0.mem_we, tv[k].we);
            chk($sformatf("v%0d_mem_addr", k), 32'(b0.mem_addr), 32'(tv[k].addr));
            if (tv[k].we)
                chk($sformatf("v%0d_mem_wdata", k), b0.mem_wdata, tv[k].wdata);
            tick();
            b0.if_req = 0; b0.dm_req = 0;
            chk($sformatf("v%0d_wait_en", k), b0.mem_en, 0);
            tick();
            chk($sformatf("v%0d_if_rvalid", k), b0.if_rvalid, tv[k].is_if);
            chk($sformatf("v%0d_dm_rvalid", k), b0.dm_rvalid, !tv[k].is_if);
            chk($sformatf("v%0d_rdata", k), tv[k].is_if ? b0.if_rdata : b0.dm_rdata, tv[k].e_rdata);
            tick();
            chk($sformatf("v%0d_idle", k), b0.busy, 0);
        end

        seq = '0; cyc = 0; last = 0; ng = 0;
        b0.if_addr = 10'h004; b0.dm_addr = 10'h3FD; b0.dm_we = 0;
        tick();
        b0.if_req = 1; b0.dm_req = 1;
        while (ng < 11 && cyc < 200) begin
            tick();
            cyc++;
            if (b0.if_gnt || b0.dm_gnt) begin
                seq = {seq[9:0], b0.dm_gnt};
                if (ng > 0)
                    chk($sformatf("gap%0d", ng), cyc - last, 4);
                last = cyc;
                ng++;
                if (b0.dm_gnt) b0.dm_req = 0;
                else b0.if_req = 0;
            end
            if (b0.dm_rvalid) b0.dm_req = 1;
            if (b0.if_rvalid) b0.if_req = 1;
        end
        chk("contest_grants", ng, 11);
        chk("contest_order", 32'(seq), 32'(11'b11101110111));

        tick();
        #2 rst_n = 0;
        #1 rst_chk("mid_dm");
        b0.dm_req = 1;
        #1 rst_n = 1;
        wait_gnt();
        chk("post_rst_dm_wins", b0.dm_gnt, 1);
        chk("post_rst_if_loses", b0.if_gnt, 0);
        b0.dm_req = 0;
        wait_gnt();
        chk("fetch_next", b0.if_gnt, 1);
        b0.if_req = 0;
        tick();
        chk("mid_if_busy", b0.busy, 1);
        #2 rst_n = 0;
        #1 rst_chk("mid_if");
        repeat (2) tick();
        rst_n = 1;
        nrv = 0;
        repeat (8) begin
            tick();
            nrv += int'(b0.if_rvalid);
        end
        chk("no_if_rvalid", nrv, 0);

        tick();
        b1.dm_req = 1; b1.dm_addr = 10'h010; b1.dm_we = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 2) b1.dm_req = 0;
            chk($sformatf("lat_busy_c%0d", c), b1.busy, c <= 6);
            chk($sformatf("lat_gnt_c%0d", c), b1.dm_gnt, c == 1);
            chk($sformatf("lat_en_c%0d", c), b1.mem_en, c == 1);
            chk($sformatf("lat_rvalid_c%0d", c), b1.dm_rvalid, c == 6);
            chk($sformatf("lat_rdata_c%0d", c), b1.dm_rdata, c >= 6 ? 32'hA5000010 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
